pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_pkg.sv | 11 +
 rtl/stretch_counter.sv | 28 ++
 rtl/pulse_stretcher.sv | 78 +++++++
 tb/tb_pulse_stretcher.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state type and default counter width.
package pulse_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    STRETCH = 1'b1
  } state_t;

endpackage

// File: rtl/stretch_counter.sv
// Loadable down-counter used to time one stretch; load wins over decrement.
import pulse_pkg::*;

module stretch_counter #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: synchronous clear, reload on accepted trigger, else count down.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt    = r_cnt;
  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each accepted trigger holds level_out high for max(len,1) cycles.
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN -- any trigger during a stretch
// reloads the counter (extends the stretch) and dropped is tied low.
import pulse_pkg::*;

module pulse_stretcher #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] len,
  output logic             level_out,
  output logic             done,
  output logic             dropped
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_cnt;
  logic             w_is_one;
  logic             w_in_stretch;
  logic             w_accept;
  logic             w_dec;

  // len=0 is treated as a one-cycle stretch.
  assign w_n          = (len == '0) ? CNT_W'(1) : len;
  assign w_in_stretch = (r_state == STRETCH);

  // State register; reset beats any trigger on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Trigger acceptance and next-state decode.
  always_comb begin
    w_accept = 1'b0;
    w_next   = r_state;
    w_dec    = 1'b0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    w_accept = pulse_in;
`else
    // The last cycle of a stretch always accepts, so a held trigger never gaps.
    w_accept = pulse_in && (!w_in_stretch || w_is_one);
`endif
    case (r_state)
      IDLE:    if (w_accept) w_next = STRETCH;
      STRETCH: begin
        w_dec = !w_accept;
        if (!w_accept && w_is_one) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  stretch_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_n),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_is_one   (w_is_one)
  );

  // level_out comes straight from the state flop, so it has no path from pulse_in.
  assign level_out = w_in_stretch;
  assign done      = w_in_stretch && w_is_one && !w_accept;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign dropped = 1'b0;
`else
  assign dropped = pulse_in && w_in_stretch && (w_cnt > CNT_W'(1));
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scenario-driven bench; expected {level_out,done,dropped} per edge go through a queue.
module tb_pulse_stretcher;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             pulse_in;
  logic [CNT_W-1:0] len;
  logic             level_out;
  logic             done;
  logic             dropped;

  int total = 0;
  int bad   = 0;
  logic [2:0] q[$];

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  pulse_stretcher #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .len       (len),
    .level_out (level_out),
    .done      (done),
    .dropped   (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Drives inputs for the cycle ending at the next edge and waits to the sample point.
  task automatic drive(input logic p, input logic r, input logic [CNT_W-1:0] l);
    pulse_in = p;
    rst_n    = r;
    len      = l;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] e;
    for (int k = 0; k <= 3; k++) begin
      q.push_back(3'b000);
      // Trigger coincides with reset at edge 0 and must be ignored.
      drive(k == 0, k != 0, 8'd4);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL reset edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [2:0] e;
    for (int k = 0; k <= 16; k++) begin
      q.push_back({k >= 11 && k <= 14, k == 14, 1'b0});
      drive(k == 10, 1'b1, 8'd4);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL basic edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len_zero();
    logic [2:0] e;
    for (int k = 0; k <= 3; k++) begin
      q.push_back({k == 1, k == 1, 1'b0});
      drive(k == 0, 1'b1, 8'd0);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL len_zero edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len_change();
    logic [2:0] e;
    for (int k = 0; k <= 6; k++) begin
      q.push_back({k >= 1 && k <= 3, k == 3, 1'b0});
      drive(k == 0, 1'b1, (k == 0) ? 8'd3 : 8'd15);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL len_change edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overlap();
    logic [2:0] e;
    int last;
    last = RETRIG ? 7 : 5;
    for (int k = 0; k <= 10; k++) begin
      q.push_back({k >= 1 && k <= last, k == last, !RETRIG && k == 2});
      drive(k == 0 || k == 2, 1'b1, 8'd5);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL overlap edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cnt_one();
    logic [2:0] e;
    for (int k = 0; k <= 8; k++) begin
      q.push_back({k >= 1 && k <= 6, k == 6, 1'b0});
      drive(k == 0 || k == 3, 1'b1, 8'd3);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL cnt_one edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [2:0] e;
    for (int k = 0; k <= 10; k++) begin
      q.push_back({k >= 1 && k <= 3, 1'b0, 1'b0});
      drive(k == 0, k != 3, 8'd8);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL reset_abort edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int last;
    last = RETRIG ? 21 : 20;
    for (int k = 0; k <= 24; k++) begin
      q.push_back({k >= 1 && k <= last, k == last, !RETRIG && k <= 19 && k[0]});
      drive(k <= 19, 1'b1, 8'd2);
      e = q.pop_front();
      total++;
      if ({level_out, done, dropped} !== e) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got=%b want=%b", k, {level_out, done, dropped}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    pulse_in = 1'b0;
    rst_n    = 1'b0;
    len      = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_len_zero();
    test_len_change();
    test_overlap();
    test_cnt_one();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
